// File: rtl/sync_fifo_stream_reader.sv
// Drain side of sync_fifo: issues FIFO reads against a 3-word credit and replays the words as a valid/ready stream.
// Optional define FIFO_RD_STATS_EN adds a free-running handshake counter (pop_count).
module sync_fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  idle
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  pop_count
`endif
);

    localparam int DEPTH = 3;

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end

    logic [DATA_WIDTH-1:0] buf_q [DEPTH];
    logic [DATA_WIDTH-1:0] buf_d [DEPTH];
    logic [1:0]            head_q, head_d;
    logic [1:0]            tail_q, tail_d;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;

    logic                  credit;
    logic                  push;
    logic                  pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts words already buffered plus the one the FIFO is returning;
    // a same-cycle pop is deliberately ignored so m_ready never reaches fifo_rd_en.
    assign credit     = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3;
    assign fifo_rd_en = !reset && !fifo_empty && !flush && credit;

    assign m_valid = (count_q != 2'd0);
    assign m_data  = buf_q[head_q];
    assign idle    = (count_q == 2'd0) && !inflight_q;

    assign pop  = m_valid && m_ready;
    assign push = inflight_q && !flush;

    always_comb begin
        buf_d      = buf_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = fifo_rd_en;

        if (flush) begin
            // A handshake in the flush cycle has already been taken downstream;
            // everything else, including the word on fifo_dout, is dropped.
            head_d  = 2'd0;
            tail_d  = 2'd0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                buf_d[tail_q] = fifo_dout;
                tail_d        = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [CNT_WIDTH-1:0] pop_count_q, pop_count_d;

    always_comb begin
        pop_count_d = pop_count_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    end

    // Only reset clears the counter; flush leaves it running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_count_q <= '0;
        end else begin
            pop_count_q <= pop_count_d;
        end
    end

    assign pop_count = pop_count_q;
`endif

endmodule

// File: doc/sync_fifo_stream_reader.md
Name: sync_fifo_stream_reader

Overview:
- Drain side of sync_fifo: pops words from the FIFO read port (rd_en/empty/dout) and presents them as a valid/ready stream.
- Absorbs the FIFO's 1-cycle registered read latency in a 3-entry output buffer.
- Sustains 1 word/cycle with no combinational path from m_ready to fifo_rd_en.
- Sits between sync_fifo and any downstream stream consumer.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- CNT_WIDTH, 16, width of pop_count (optional feature only).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read request.
- fifo_dout  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read.
- flush  input  1  synchronous discard of buffered and in-flight words.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream ready.
- m_data  output  DATA_WIDTH  stream data.
- idle  output  1  no buffered or in-flight words.

Behaviour:
- Clock and reset: clk; reset asynchronous, active-high.
- Reset state: buf_count=0, inflight=0, all buffer entries 0, m_data=0, m_valid=0, fifo_rd_en=0 (forced 0 while reset high), idle=1.
- FIFO read model:
  - A read is accepted in cycle N iff fifo_rd_en && !fifo_empty.
  - fifo_dout holds that word during cycle N+1.
  - The reader only counts accepted reads, never raw rd_en.
- State:
  - 3-entry in-order buffer with head/tail pointers, each wrapping 2 to 0.
  - buf_count is 0..3.
  - inflight is a 1-bit register, set on the edge after an accepted read.
- Read issue, combinational from registers and inputs only:
  - fifo_rd_en = !reset && !fifo_empty && !flush && (buf_count + inflight < 3).
  - m_ready never feeds fifo_rd_en.
- Capture: when inflight=1 and flush=0, fifo_dout is written at tail on that edge.
- Output:
  - m_valid = (buf_count != 0).
  - m_data = entry at head.
  - Pop on m_valid && m_ready: head advances.
- Simultaneous capture and pop: buf_count unchanged, order preserved.
- Latency: FIFO non-empty in cycle N with credit available → fifo_rd_en in N, m_valid in N+2.
- Throughput: with m_ready held 1, one word per cycle steady state.
- Backpressure: with m_ready=0, at most 3 words are held (buffered + in-flight); fifo_rd_en stays 0 until a pop frees credit.
- m_data/m_valid stable while m_valid && !m_ready.
- flush=1 in cycle N:
  - A handshake in N still counts as transferred.
  - On the edge ending N: buf_count=0, pointers reset, inflight=0.
  - The in-flight word (fifo_dout in N) is discarded.
  - No read is issued in N.
  - m_valid=0 and idle=1 in N+1; normal operation resumes in N+1.
- idle = (buf_count==0) && !inflight.
- Reset mid-operation: all state clears immediately. Words the FIFO already popped are lost; this is by design.

Optional Feature:
- Macro: FIFO_RD_STATS_EN.
- Defined: adds output port pop_count [CNT_WIDTH-1:0].
  - Increments by 1 on every m_valid && m_ready handshake, wrapping at 2^CNT_WIDTH.
  - Cleared only by reset; flush does not clear it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Streaming: reset, FIFO preloaded with 0x11,0x22,0x33, m_ready=1 → fifo_rd_en high cycles 0-2; m_valid cycles 2-4 carrying 0x11,0x22,0x33; idle=1 at cycle 5.
- Backpressure: FIFO holds 0xA0..0xA4, m_ready=0 → exactly 3 accepted reads, then fifo_rd_en=0; m_data=0xA0 stable. Raise m_ready → 0xA0..0xA4 in order, no gaps after the first.
- Empty: fifo_empty=1 for 20 cycles → fifo_rd_en=0, m_valid=0, idle=1 throughout.
- Flush: 2 words buffered plus 1 in flight, flush pulsed 1 cycle → next cycle m_valid=0, idle=1. In-flight word never appears on m_data; next FIFO word appears 2 cycles after reads resume.
- Reset mid-burst: assert reset with buf_count=3 → m_valid=0, m_data=0, fifo_rd_en=0 immediately (asynchronous); after release, streaming restarts from the current FIFO head.
- With FIFO_RD_STATS_EN: 10 handshakes interleaved with random m_ready stalls and one flush → pop_count=10.
